switch_rr_scheduler: RTL and testbench

Round-robin output scheduler for the simple router. It sits between the per-input first-word-fall-through FIFOs and the output ports. Each cycle it grants at most one input to each output, pops the granted FIFO, and registers the word into a per-output holding stage that honours output backpressure. Words addressed to a non-existent output are popped, discarded and counted.

---
 rtl/switch_rr_scheduler.sv | 111 +++++++++++
 tb/tb_switch_rr_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_rr_scheduler.sv
// Round-robin output scheduler: rotating-priority grant per output, pops the winning input FIFO.
// One cycle from pop to out_valid; an occupied output blocks new grants until out_ready; bad destinations are dropped and counted.
module switch_rr_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int INPUT_QTY  = 2,
    parameter int OUTPUT_QTY = 2,
    localparam int DW = $clog2(OUTPUT_QTY),
    localparam int SW = $clog2(INPUT_QTY)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [INPUT_QTY-1:0]                     req_valid,
    input  logic [INPUT_QTY-1:0][DATA_WIDTH+DW-1:0]  req_data,
    output logic [INPUT_QTY-1:0]                     req_ready,
    input  logic [OUTPUT_QTY-1:0]                    out_ready,
    output logic [OUTPUT_QTY-1:0]                    out_valid,
    output logic [OUTPUT_QTY-1:0][DATA_WIDTH-1:0]    out_data,
    output logic [OUTPUT_QTY-1:0][SW-1:0]            out_src,
    output logic [15:0]                              drop_count
);

    localparam int CW = $clog2(INPUT_QTY + 1);

    logic [SW-1:0]         ptr     [OUTPUT_QTY];
    logic [SW-1:0]         win_idx [OUTPUT_QTY];
    logic [OUTPUT_QTY-1:0] out_free;
    logic [OUTPUT_QTY-1:0] win_vld;
    logic [OUTPUT_QTY-1:0] grant;
    logic [INPUT_QTY-1:0]  bad_dst;
    logic [CW-1:0]         drop_n;
    logic [16:0]           drop_sum;

    function automatic logic [DW-1:0] dest_of(input logic [DATA_WIDTH+DW-1:0] w);
        return w[DW-1:0];
    endfunction

    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= INPUT_QTY) s = s - INPUT_QTY;
        return SW'(s);
    endfunction

    assign out_free = ~out_valid | out_ready;
    assign grant    = win_vld & out_free & {OUTPUT_QTY{reset}};

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        win_vld = '0;
        for (int o = 0; o < OUTPUT_QTY; o++) begin
            win_idx[o] = '0;
            for (int k = 1; k <= INPUT_QTY; k++) begin
                if (!win_vld[o] && req_valid[rr_index(ptr[o], k)] &&
                    int'(dest_of(req_data[rr_index(ptr[o], k)])) == o) begin
                    win_vld[o] = 1'b1;
                    win_idx[o] = rr_index(ptr[o], k);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < INPUT_QTY; i++) begin
            bad_dst[i] = req_valid[i] && (int'(dest_of(req_data[i])) >= OUTPUT_QTY);
        end
    end

    // Each input names a single destination, so at most one grant can select it.
    always_comb begin
        req_ready = '0;
        drop_n    = '0;
        if (reset) begin
            for (int i = 0; i < INPUT_QTY; i++) begin
                if (bad_dst[i]) begin
                    req_ready[i] = 1'b1;
                    drop_n       = drop_n + CW'(1);
                end
            end
            for (int o = 0; o < OUTPUT_QTY; o++) begin
                if (grant[o]) req_ready[win_idx[o]] = 1'b1;
            end
        end
    end

    assign drop_sum = {1'b0, drop_count} + 17'(drop_n);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid  <= '0;
            out_data   <= '0;
            out_src    <= '0;
            drop_count <= '0;
            for (int o = 0; o < OUTPUT_QTY; o++) begin
                ptr[o] <= SW'(INPUT_QTY - 1);
            end
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int o = 0; o < OUTPUT_QTY; o++) begin
                if (out_free[o]) begin
                    out_valid[o] <= grant[o];
                    if (grant[o]) begin
                        out_data[o] <= req_data[win_idx[o]][DATA_WIDTH+DW-1:DW];
                        out_src[o]  <= win_idx[o];
                        ptr[o]      <= win_idx[o];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Bench for switch_rr_scheduler: a 2x2 instance for routing tests, a 2x3 instance for bad destinations.
module tb_switch_rr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [1:0]      req_valid, req_ready, out_ready, out_valid;
    logic [1:0][8:0] req_data;
    logic [1:0][7:0] out_data;
    logic [1:0][0:0] out_src;
    logic [15:0]     drop_count;

    logic [1:0]      req_valid1, req_ready1;
    logic [1:0][9:0] req_data1;
    logic [2:0]      out_ready1, out_valid1;
    logic [2:0][7:0] out_data1;
    logic [2:0][0:0] out_src1;
    logic [15:0]     drop_count1;

    switch_rr_scheduler #(.DATA_WIDTH(8), .INPUT_QTY(2), .OUTPUT_QTY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .drop_count(drop_count)
    );

    switch_rr_scheduler #(.DATA_WIDTH(8), .INPUT_QTY(2), .OUTPUT_QTY(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
        .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_src(out_src1), .drop_count(drop_count1)
    );

    int checks = 0;
    int errors = 0;

    // Input FIFO models for dut0 and expected {src, payload} per output.
    logic [8:0] fq0[$], fq1[$];
    logic [8:0] exp0[$], exp1[$];

    // Values sampled at the falling edge before each rising edge.
    logic [1:0]      o_rdy, o_vld;
    logic [1:0][7:0] o_dat;
    logic [1:0][0:0] o_src;
    logic [15:0]     o_drop;
    logic [1:0]      o1_rdy;
    logic [2:0]      o1_vld;
    logic [7:0]      o1_dat2;
    logic [15:0]     o1_drop;

    task automatic drive_heads();
        req_valid[0] = (fq0.size() > 0);
        req_valid[1] = (fq1.size() > 0);
        req_data[0]  = (fq0.size() > 0) ? fq0[0] : 9'h0;
        req_data[1]  = (fq1.size() > 0) ? fq1[0] : 9'h0;
    endtask

    task automatic tick();
        @(negedge clk);
        o_rdy   = req_ready;
        o_vld   = out_valid;
        o_dat   = out_data;
        o_src   = out_src;
        o_drop  = drop_count;
        o1_rdy  = req_ready1;
        o1_vld  = out_valid1;
        o1_dat2 = out_data1[2];
        o1_drop = drop_count1;
        @(posedge clk);
        #1;
        if (o_rdy[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (o_rdy[1] && fq1.size() > 0) void'(fq1.pop_front());
        drive_heads();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fq0.push_back({8'hF0, 1'b1});
        fq1.push_back({8'hF1, 1'b0});
        drive_heads();
        req_valid1 = 2'b11;
        req_data1[0] = {8'hE8, 2'd3};
        req_data1[1] = {8'hE9, 2'd3};
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_rdy !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", o_rdy); end
            checks++;
            if (o_vld !== 2'b00 || o_drop !== 16'h0) begin
                errors++; $display("FAIL reset_out got vld=%b drop=%h exp vld=00 drop=0000", o_vld, o_drop);
            end
            checks++;
            if (o1_rdy !== 2'b00 || o1_vld !== 3'b000 || o1_drop !== 16'h0) begin
                errors++; $display("FAIL reset_dut1 got rdy=%b vld=%b drop=%h exp 00/000/0000", o1_rdy, o1_vld, o1_drop);
            end
        end
        checks++;
        if (o_dat !== 16'h0 || o_src !== 2'b00) begin
            errors++; $display("FAIL reset_data got dat=%h src=%b exp 0000/00", o_dat, o_src);
        end
        reset = 1'b1;
        req_valid1 = 2'b00;
        fq0.delete();
        fq1.delete();
        drive_heads();
    endtask

    task automatic test_contention();
        logic [8:0] e;
        int started;
        int budget;
        started = 0;
        budget = 0;
        out_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            fq0.push_back({8'hA0 + 8'(k), 1'b1});
            fq1.push_back({8'hB0 + 8'(k), 1'b1});
            exp1.push_back({1'b0, 8'hA0 + 8'(k)});
            exp1.push_back({1'b1, 8'hB0 + 8'(k)});
        end
        drive_heads();
        while (exp1.size() > 0 && budget < 30) begin
            tick();
            budget++;
            if (started != 0) begin
                checks++;
                if (o_vld[1] !== 1'b1) begin errors++; $display("FAIL contention_bubble got vld=%b exp 1", o_vld[1]); end
            end
            if (o_vld[1] === 1'b1) begin
                e = exp1.pop_front();
                started = 1;
                checks++;
                if ({o_src[1], o_dat[1]} !== e) begin
                    errors++; $display("FAIL contention_word got src=%0d dat=%h exp src=%0d dat=%h", o_src[1], o_dat[1], e[8], e[7:0]);
                end
            end
            checks++;
            if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL contention_out0 got vld=%b exp 0", o_vld[0]); end
        end
        checks++;
        if (exp1.size() != 0) begin errors++; $display("FAIL contention_timeout got %0d left exp 0", exp1.size()); end
        exp1.delete();
    endtask

    task automatic test_parallel();
        logic [8:0] e;
        fq0.push_back({8'h11, 1'b0});
        fq1.push_back({8'h22, 1'b1});
        exp0.push_back({1'b0, 8'h11});
        exp1.push_back({1'b1, 8'h22});
        drive_heads();
        tick();
        checks++;
        if (o_rdy !== 2'b11) begin errors++; $display("FAIL parallel_ready got %b exp 11", o_rdy); end
        tick();
        checks++;
        if (o_vld !== 2'b11) begin errors++; $display("FAIL parallel_valid got %b exp 11", o_vld); end
        e = exp0.pop_front();
        checks++;
        if ({o_src[0], o_dat[0]} !== e) begin errors++; $display("FAIL parallel_out0 got %h exp %h", {o_src[0], o_dat[0]}, e); end
        e = exp1.pop_front();
        checks++;
        if ({o_src[1], o_dat[1]} !== e) begin errors++; $display("FAIL parallel_out1 got %h exp %h", {o_src[1], o_dat[1]}, e); end
        tick();
        checks++;
        if (o_vld !== 2'b00) begin errors++; $display("FAIL parallel_drain got %b exp 00", o_vld); end
    endtask

    task automatic test_backpressure();
        logic [8:0] e;
        out_ready = 2'b10;
        fq0.push_back({8'h55, 1'b0});
        fq0.push_back({8'h66, 1'b0});
        exp0.push_back({1'b0, 8'h55});
        exp0.push_back({1'b0, 8'h66});
        drive_heads();
        tick();
        checks++;
        if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_first_pop got %b exp 1", o_rdy[0]); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (o_rdy[0] !== 1'b0 || o_vld[0] !== 1'b1 || o_dat[0] !== 8'h55) begin
                errors++; $display("FAIL bp_hold got rdy=%b vld=%b dat=%h exp 0/1/55", o_rdy[0], o_vld[0], o_dat[0]);
            end
        end
        out_ready = 2'b11;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (o_vld[0] !== 1'b1) begin
                errors++; $display("FAIL bp_release_valid got %b exp 1", o_vld[0]);
            end else begin
                e = exp0.pop_front();
                checks++;
                if ({o_src[0], o_dat[0]} !== e) begin errors++; $display("FAIL bp_release_word got %h exp %h", {o_src[0], o_dat[0]}, e); end
            end
            if (c == 0) begin
                checks++;
                if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL bp_handoff_pop got %b exp 1", o_rdy[0]); end
            end
        end
        tick();
        checks++;
        if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", o_vld[0]); end
        exp0.delete();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            fq0.push_back({8'hC0 + 8'(k), 1'b0});
            fq1.push_back({8'hD0 + 8'(k), 1'b0});
        end
        drive_heads();
        tick();
        checks++;
        if (o_rdy !== 2'b10) begin errors++; $display("FAIL rmid_first_grant got %b exp 10", o_rdy); end
        tick();
        checks++;
        if (o_rdy !== 2'b01 || o_dat[0] !== 8'hD0) begin
            errors++; $display("FAIL rmid_second_grant got rdy=%b dat=%h exp 01/d0", o_rdy, o_dat[0]);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (o_rdy !== 2'b00) begin errors++; $display("FAIL rmid_no_pop got %b exp 00", o_rdy); end
        reset = 1'b1;
        tick();
        checks++;
        if (o_vld !== 2'b00 || o_rdy !== 2'b01) begin
            errors++; $display("FAIL rmid_after got vld=%b rdy=%b exp 00/01", o_vld, o_rdy);
        end
        tick();
        checks++;
        if (o_vld[0] !== 1'b1 || o_src[0] !== 1'b0 || o_dat[0] !== 8'hC1) begin
            errors++; $display("FAIL rmid_word got vld=%b src=%0d dat=%h exp 1/0/c1", o_vld[0], o_src[0], o_dat[0]);
        end
        fq0.delete();
        fq1.delete();
        drive_heads();
        tick();
        tick();
    endtask

    task automatic test_bad_dest();
        req_valid1 = 2'b11;
        req_data1[0] = {8'h77, 2'd2};
        req_data1[1] = {8'hE0, 2'd3};
        tick();
        checks++;
        if (o1_rdy !== 2'b11) begin errors++; $display("FAIL bad_first_pop got %b exp 11", o1_rdy); end
        req_valid1 = 2'b10;
        for (int k = 1; k < 5; k++) begin
            req_data1[1] = {8'hE0 + 8'(k), 2'd3};
            tick();
            checks++;
            if (o1_rdy !== 2'b10) begin errors++; $display("FAIL bad_pop got %b exp 10", o1_rdy); end
            checks++;
            if (k == 1) begin
                if (o1_vld !== 3'b100 || o1_dat2 !== 8'h77) begin
                    errors++; $display("FAIL bad_good_word got vld=%b dat=%h exp 100/77", o1_vld, o1_dat2);
                end
            end else if (o1_vld !== 3'b000) begin
                errors++; $display("FAIL bad_no_output got %b exp 000", o1_vld);
            end
        end
        req_valid1 = 2'b00;
        tick();
        checks++;
        if (o1_drop !== 16'd5 || o1_vld !== 3'b000 || o1_rdy !== 2'b00) begin
            errors++; $display("FAIL bad_count got drop=%0d vld=%b rdy=%b exp 5/000/00", o1_drop, o1_vld, o1_rdy);
        end
        req_valid1 = 2'b10;
        tick();
        req_valid1 = 2'b00;
        tick();
        checks++;
        if (o1_drop !== 16'd6) begin errors++; $display("FAIL bad_count6 got %0d exp 6", o1_drop); end
        req_valid1 = 2'b11;
        req_data1[0] = {8'hEE, 2'd3};
        for (int n = 0; n < 32764; n++) tick();
        checks++;
        if (o1_rdy !== 2'b11) begin errors++; $display("FAIL bad_dual_pop got %b exp 11", o1_rdy); end
        req_valid1 = 2'b00;
        tick();
        checks++;
        if (o1_drop !== 16'hFFFE) begin errors++; $display("FAIL bad_near_sat got %h exp fffe", o1_drop); end
        for (int r = 0; r < 2; r++) begin
            req_valid1 = 2'b11;
            tick();
            req_valid1 = 2'b00;
            tick();
            checks++;
            if (o1_drop !== 16'hFFFF) begin errors++; $display("FAIL bad_saturate got %h exp ffff", o1_drop); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        out_ready  = 2'b11;
        req_valid  = 2'b00;
        req_data   = '0;
        req_valid1 = 2'b00;
        req_data1  = '0;
        out_ready1 = 3'b111;
        test_reset();
        test_contention();
        test_parallel();
        test_backpressure();
        test_reset_mid();
        test_bad_dest();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
